// File: rtl/spawn_in_arbiter.sv
// spawn_in_arbiter: packet-granular round-robin merge of NUM_PORTS spawn streams into one tagged stream
// Ports: aclk/interconnect_aresetn (async active-low reset); s_tvalid/s_tready/s_tdata/s_tdest/s_tlast
// per-port slave beats (port i at [64*i+:64] / [5*i+:5]); m_tvalid/m_tready/m_tid/m_tdest/m_tdata/m_tlast
// merged master stream with m_tid = source port. Define SPAWN_IN_ARBITER_OUTREG_EN to register m_* through
// a 2-entry skid buffer; otherwise the locked port is passed through combinationally.
module spawn_in_arbiter #(
  parameter int NUM_PORTS = 16,
  localparam int TID_W = $clog2(NUM_PORTS)
) (
  input  logic                   aclk,
  input  logic                   interconnect_aresetn,
  input  logic [NUM_PORTS-1:0]   s_tvalid,
  output logic [NUM_PORTS-1:0]   s_tready,
  input  logic [64*NUM_PORTS-1:0] s_tdata,
  input  logic [5*NUM_PORTS-1:0] s_tdest,
  input  logic [NUM_PORTS-1:0]   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TID_W-1:0]       m_tid,
  output logic [4:0]             m_tdest,
  output logic [63:0]            m_tdata,
  output logic                   m_tlast
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [TID_W-1:0] grant_q, grant_d, rr_q, rr_d, pick;
  logic [TID_W:0] scan;
  logic found, lock, sel_valid, sel_last, in_rdy, acc;
  logic [63:0] sel_data;
  logic [4:0] sel_dest;
  assign lock = state_q == LOCKED;
  assign sel_valid = s_tvalid[grant_q];
  assign sel_last = s_tlast[grant_q];
  assign sel_data = s_tdata[64*grant_q +: 64];
  assign sel_dest = s_tdest[5*grant_q +: 5];
  assign acc = lock & sel_valid & in_rdy;
  assign s_tready = lock ? {{(NUM_PORTS-1){1'b0}}, in_rdy} << grant_q : '0;
  // scan = rr_q + k modulo NUM_PORTS; one extra bit keeps the sum from overflowing before the wrap
  always_comb begin
    pick = '0;
    found = 1'b0;
    scan = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan = {1'b0, rr_q} + (TID_W+1)'(k);
      if (scan >= (TID_W+1)'(NUM_PORTS)) scan = scan - (TID_W+1)'(NUM_PORTS);
      if (!found && s_tvalid[scan[TID_W-1:0]]) begin
        pick = scan[TID_W-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    if (!lock && found) begin
      state_d = LOCKED;
      grant_d = pick;
    end
    if (acc && sel_last) begin
      state_d = IDLE;
      rr_d = grant_q == TID_W'(NUM_PORTS-1) ? '0 : grant_q + 1'b1;
    end
  end
  always_ff @(posedge aclk or negedge interconnect_aresetn) begin
    if (!interconnect_aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
    end
  end
`ifdef SPAWN_IN_ARBITER_OUTREG_EN
  localparam int EW = TID_W + 70;
  logic [EW-1:0] buf_q [2];
  logic wr_q, rd_q, pop;
  logic [1:0] cnt_q;
  // input ready depends only on buffer occupancy, so m_tready never reaches s_tready combinationally
  assign in_rdy = cnt_q != 2'd2;
  assign m_tvalid = cnt_q != 2'd0;
  assign pop = m_tvalid & m_tready;
  assign {m_tid, m_tdest, m_tdata, m_tlast} = buf_q[rd_q];
  always_ff @(posedge aclk or negedge interconnect_aresetn) begin
    if (!interconnect_aresetn) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (acc) buf_q[wr_q] <= {grant_q, sel_dest, sel_data, sel_last};
      wr_q <= wr_q ^ acc;
      rd_q <= rd_q ^ pop;
      cnt_q <= cnt_q + {1'b0, acc} - {1'b0, pop};
    end
  end
`else
  assign in_rdy = m_tready;
  assign m_tvalid = lock & sel_valid;
  assign m_tid = lock ? grant_q : '0;
  assign m_tdest = lock ? sel_dest : '0;
  assign m_tdata = lock ? sel_data : '0;
  assign m_tlast = lock & sel_last;
`endif
endmodule

// File: tb/tb_spawn_in_arbiter.sv
// tb_spawn_in_arbiter: directed and randomized checks of spawn_in_arbiter against a packet-level reference model
module tb_spawn_in_arbiter;
  localparam int N = 5;
  localparam int TW = $clog2(N);
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] tv = '0, tr, tl = '0, hs;
  logic [64*N-1:0] td = '0;
  logic [5*N-1:0] tdst = '0;
  logic mv, mr = 1'b1, ml;
  logic [TW-1:0] mid;
  logic [4:0] mdst;
  logic [63:0] mdat;
  int errors = 0, checks = 0;
  bit locked = 0;
  int g = 0, rr = 0;
  int sq[$];
  int seq[N], rem[N], exp_seq[N];
  spawn_in_arbiter #(.NUM_PORTS(N)) dut (
    .aclk(clk), .interconnect_aresetn(rst_n),
    .s_tvalid(tv), .s_tready(tr), .s_tdata(td), .s_tdest(tdst), .s_tlast(tl),
    .m_tvalid(mv), .m_tready(mr), .m_tid(mid), .m_tdest(mdst), .m_tdata(mdat), .m_tlast(ml)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic put(input int p, input logic v, input logic [63:0] d, input logic [4:0] de, input logic l);
    tv[p] = v;
    td[64*p +: 64] = d;
    tdst[5*p +: 5] = de;
    tl[p] = l;
  endtask
  // compare outputs with the model, then advance the model by the handshake that the coming edge performs
  task automatic cyc();
    logic [N-1:0] etr;
    etr = locked ? (N'(mr) << g) : '0;
    chk("s_tready", 64'(tr), 64'(etr));
    chk("m_tvalid", mv, locked ? tv[g] : 1'b0);
    chk("m_tid", mid, locked ? g : 0);
    chk("m_tdata", mdat, locked ? td[64*g +: 64] : 64'd0);
    chk("m_tdest", mdst, locked ? tdst[5*g +: 5] : 5'd0);
    chk("m_tlast", ml, locked ? tl[g] : 1'b0);
    if (!locked) begin
      for (int k = 0; k < N; k++) if (tv[(rr + k) % N]) begin
        g = (rr + k) % N;
        locked = 1;
        break;
      end
    end else if (tv[g] && mr && tl[g]) begin
      rr = (g + 1) % N;
      locked = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic go();
    #1;
    cyc();
  endtask
  initial begin
    #1;
    chk("rst_tvalid", mv, 0);
    chk("rst_tready", 64'(tr), 0);
    chk("rst_tid", mid, 0);
    chk("rst_tdata", mdat, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // ports 0 and 2 from reset; port 0 re-requests
    put(0, 1, 64'h100, 5'd1, 1);
    put(2, 1, 64'h200, 5'd3, 1);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mv && mr) sq.push_back(int'(mid));
      cyc();
      if (sq.size() > 0 && sq[$] == 2) tv[2] = 1'b0;
      if (sq.size() == 3) tv[0] = 1'b0;
    end
    chk("t2_count", sq.size(), 3);
    if (sq.size() == 3) begin
      chk("t2_first", sq[0], 0);
      chk("t3_rr_win", sq[1], 2);
      chk("t2_third", sq[2], 0);
    end
    // port 3 three beats
    put(3, 1, 64'hA, 5'd2, 0);
    #1 chk("t1_arb_cycle", mv, 0);
    cyc();
    #1;
    chk("t1_a_valid", mv, 1);
    chk("t1_a_tid", mid, 3);
    chk("t1_a_data", mdat, 64'hA);
    chk("t1_a_dest", mdst, 2);
    chk("t1_a_last", ml, 0);
    cyc();
    put(3, 1, 64'hB, 5'd2, 0);
    #1 chk("t1_b_data", mdat, 64'hB);
    cyc();
    put(3, 1, 64'hC, 5'd2, 1);
    #1;
    chk("t1_c_data", mdat, 64'hC);
    chk("t1_c_last", ml, 1);
    cyc();
    put(3, 0, 64'h0, 5'd0, 0);
    #1 chk("t1_bubble", mv, 0);
    cyc();
    // port 1 four beats with a 5-cycle stall on beat 2, port 3 waiting
    put(3, 1, 64'h300, 5'd4, 1);
    begin
      int b = 0, stall = 0;
      for (int i = 0; i < 20 && b < 4; i++) begin
        put(1, 1, 64'h1000 + 64'(b), 5'd4, b == 3);
        mr = (b == 1 && stall < 5) ? 1'b0 : 1'b1;
        #1;
        if (!mr) begin
          chk("t4_hold_data", mdat, 64'h1001);
          chk("t4_hold_rdy", tr[1], 0);
          chk("t4_hold_tid", mid, 1);
          stall++;
        end
        if (mv && mr) begin
          chk("t4_beat", mdat, 64'h1000 + 64'(b));
          b++;
        end
        cyc();
      end
      chk("t4_beats", b, 4);
      chk("t4_stalls", stall, 5);
    end
    mr = 1'b1;
    tv[1] = 1'b0;
    go();
    #1 chk("t4_p3_after", mid, 3);
    cyc();
    tv[3] = 1'b0;
    // reset during beat 2 of a port-2 packet
    put(2, 1, 64'h2000, 5'd1, 0);
    go();
    go();
    put(2, 1, 64'h2001, 5'd1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", mv, 0);
    chk("t5_rst_tready", 64'(tr), 0);
    chk("t5_rst_tid", mid, 0);
    chk("t5_rst_tdata", mdat, 0);
    chk("t5_rst_tdest", mdst, 0);
    chk("t5_rst_tlast", ml, 0);
    locked = 0;
    g = 0;
    rr = 0;
    tv = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    put(0, 1, 64'h3000, 5'd7, 1);
    put(4, 1, 64'h4000, 5'd8, 1);
    go();
    #1 chk("t5_grant0", mid, 0);
    cyc();
    tv[0] = 1'b0;
    go();
    #1 chk("t6_p4", mid, 4);
    cyc();
    tv[4] = 1'b0;
    put(0, 1, 64'h5000, 5'd1, 1);
    put(1, 1, 64'h5100, 5'd1, 1);
    go();
    #1 chk("t6_wrap", mid, 0);
    cyc();
    tv[0] = 1'b0;
    go();
    go();
    tv = '0;
    go();
    // random traffic: beat payload encodes {port, per-port sequence number}
    for (int p = 0; p < N; p++) begin
      seq[p] = 0;
      rem[p] = 0;
      exp_seq[p] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        if (rem[p] == 0) rem[p] = $urandom_range(1, 4);
        put(p, $urandom_range(0, 3) != 0, {32'(p), 32'(seq[p])}, 5'(seq[p] + p), rem[p] == 1);
      end
      mr = $urandom_range(0, 3) != 0;
      #1;
      hs = tv & tr;
      if (locked && tv[g] && mr) begin
        chk("rnd_order", mdat, {32'(g), 32'(exp_seq[g])});
        exp_seq[g]++;
      end
      cyc();
      for (int p = 0; p < N; p++) if (hs[p]) begin
        seq[p]++;
        rem[p]--;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
